// File: rtl/store_activation_if.sv
// ---------------------------------------------------------------------------
// store_activation_if
//   Bundles the control, activation-stream and BRAM write-port signals of
//   store_activation so that the block, the layer controller and the bench
//   share one definition.
//
//   Groups:
//     control : store_start, base_addr, count, done
//     stream  : act_data, act_valid, act_ready
//               A byte moves when act_valid && act_ready are both high at a
//               rising clk edge. act_ready does not depend on act_valid, and
//               the producer holds act_data stable while act_valid is high
//               and no transfer has taken place.
//     bram    : BRAM_clk, BRAM_en, BRAM_rst, BRAM_wen, BRAM_addr, BRAM_din,
//               BRAM_dout
//
//   Modports:
//     master : controller / producer / memory-model side
//     slave  : store_activation side
// ---------------------------------------------------------------------------
interface store_activation_if #(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH    = 32,
    parameter int WEIGHT_WIDTH  = 8
);
    localparam int BRAM_BYTE = BRAM_WIDTH / 8;

    logic                     store_start;
    logic [BRAM_ADDR_BIT-1:0] base_addr;
    logic [15:0]              count;
    logic                     done;

    logic [WEIGHT_WIDTH-1:0]  act_data;
    logic                     act_valid;
    logic                     act_ready;

    logic                     BRAM_clk;
    logic                     BRAM_en;
    logic                     BRAM_rst;
    logic [BRAM_BYTE-1:0]     BRAM_wen;
    logic [BRAM_ADDR_BIT-1:0] BRAM_addr;
    logic [BRAM_WIDTH-1:0]    BRAM_din;
    logic [BRAM_WIDTH-1:0]    BRAM_dout;

    modport master (
        output store_start, base_addr, count, act_data, act_valid, BRAM_dout,
        input  done, act_ready, BRAM_clk, BRAM_en, BRAM_rst, BRAM_wen,
               BRAM_addr, BRAM_din
    );

    modport slave (
        input  store_start, base_addr, count, act_data, act_valid, BRAM_dout,
        output done, act_ready, BRAM_clk, BRAM_en, BRAM_rst, BRAM_wen,
               BRAM_addr, BRAM_din
    );
endinterface

// File: rtl/store_activation.sv
// ---------------------------------------------------------------------------
// store_activation
//   Collects 8-bit output activations from the conv datapath, packs them into
//   BRAM words (byte lane = byte address mod 4) and writes them back through
//   the BRAM port with per-byte write enables. A store may start and end on
//   any byte address; partial words only enable the lanes actually filled.
//
//   Ports:
//     clk         : single clock (also forwarded as BRAM_clk)
//     rst         : synchronous, active-high reset
//     bus         : store_activation_if.slave (control, byte stream, BRAM)
//     state_dbg_o : current FSM state, for observation only
//
//   Optional build macro:
//     STORE_ACTIVATION_RELU_EN - bytes with the sign bit set are stored as
//                                zero; enables and counting are unaffected.
//
//   Timing: the last byte accepted in cycle N produces its write strobe in
//   cycle N+1 and done in cycle N+2. done stays high until the next
//   accepted store_start.
// ---------------------------------------------------------------------------
module store_activation #(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH    = 32,
    parameter int WEIGHT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    store_activation_if.slave       bus,
    output logic [1:0]              state_dbg_o
);
    localparam int BRAM_BYTE = BRAM_WIDTH / 8;
    localparam int LANE_W    = $clog2(BRAM_BYTE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t                   state_q,     state_d;
    logic [15:0]              remaining_q, remaining_d;
    logic [LANE_W-1:0]        lane_q,      lane_d;
    logic [BRAM_ADDR_BIT-1:0] word_addr_q, word_addr_d;
    logic [BRAM_WIDTH-1:0]    buf_q,       buf_d;
    logic [BRAM_BYTE-1:0]     ben_q,       ben_d;
    logic                     done_q,      done_d;
    logic                     en_q,        en_d;
    logic [BRAM_BYTE-1:0]     wen_q,       wen_d;
    logic [BRAM_ADDR_BIT-1:0] addr_q,      addr_d;
    logic [BRAM_WIDTH-1:0]    din_q,       din_d;

    logic                     handshake;
    logic                     flush;
    logic [WEIGHT_WIDTH-1:0]  byte_in;
    logic [BRAM_WIDTH-1:0]    buf_merge;
    logic [BRAM_BYTE-1:0]     ben_merge;
    logic [BRAM_WIDTH-1:0]    unused_dout;

    // Read data is never needed by a write-only client.
    assign unused_dout = bus.BRAM_dout;

`ifdef STORE_ACTIVATION_RELU_EN
    // Sign bit set means a negative activation: clamp to zero before storage.
    assign byte_in = bus.act_data[WEIGHT_WIDTH-1] ? '0 : bus.act_data;
`else
    assign byte_in = bus.act_data;
`endif

    assign handshake = (state_q == COLLECT) && bus.act_valid;

    // A word is written when its top lane is filled or the store runs out.
    assign flush = handshake &&
                   ((lane_q == LANE_W'(BRAM_BYTE - 1)) || (remaining_q == 16'd1));

    // Buffer and enables as they look once the current byte is included.
    always_comb begin
        buf_merge = buf_q;
        buf_merge[lane_q*WEIGHT_WIDTH +: WEIGHT_WIDTH] = byte_in;
        ben_merge = ben_q | (BRAM_BYTE'(1) << lane_q);
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        word_addr_d = word_addr_q;
        buf_d       = buf_q;
        ben_d       = ben_q;
        done_d      = done_q;
        en_d        = 1'b0;
        wen_d       = '0;
        addr_d      = addr_q;
        din_d       = din_q;

        case (state_q)
            IDLE: begin
                if (bus.store_start) begin
                    if (bus.count != 16'd0) begin
                        remaining_d = bus.count;
                        lane_d      = bus.base_addr[LANE_W-1:0];
                        word_addr_d = {bus.base_addr[BRAM_ADDR_BIT-1:LANE_W], LANE_W'(0)};
                        buf_d       = '0;
                        ben_d       = '0;
                        done_d      = 1'b0;
                        state_d     = COLLECT;
                    end else begin
                        // Empty store completes immediately without touching BRAM.
                        done_d = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (handshake) begin
                    buf_d       = buf_merge;
                    ben_d       = ben_merge;
                    remaining_d = remaining_q - 16'd1;
                    lane_d      = lane_q + LANE_W'(1);
                    if (flush) begin
                        en_d        = 1'b1;
                        wen_d       = ben_merge;
                        din_d       = buf_merge;
                        addr_d      = word_addr_q;
                        buf_d       = '0;
                        ben_d       = '0;
                        word_addr_d = word_addr_q + BRAM_ADDR_BIT'(BRAM_BYTE);
                        lane_d      = '0;
                        if (remaining_q == 16'd1) begin
                            state_d = FINISH;
                        end
                    end
                end
            end

            FINISH: begin
                // Final write strobe is on the port this cycle.
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_q      <= '0;
            word_addr_q <= '0;
            buf_q       <= '0;
            ben_q       <= '0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            wen_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            word_addr_q <= word_addr_d;
            buf_q       <= buf_d;
            ben_q       <= ben_d;
            done_q      <= done_d;
            en_q        <= en_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign bus.act_ready = (state_q == COLLECT);
    assign bus.done      = done_q;
    assign bus.BRAM_clk  = clk;
    assign bus.BRAM_rst  = 1'b0;
    assign bus.BRAM_en   = en_q;
    assign bus.BRAM_wen  = wen_q;
    assign bus.BRAM_addr = addr_q;
    assign bus.BRAM_din  = din_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_store_activation.sv
module tb_store_activation;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int EW = AW + 4 + DW;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  store_activation_if #(.BRAM_ADDR_BIT(AW), .BRAM_WIDTH(DW), .WEIGHT_WIDTH(BW)) bus ();

  store_activation #(.BRAM_ADDR_BIT(AW), .BRAM_WIDTH(DW), .WEIGHT_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .state_dbg_o(state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0] bytes_q[$];

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_byte(input logic [7:0] b);
`ifdef STORE_ACTIVATION_RELU_EN
    return b[7] ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  task automatic push_exp(input logic [AW-1:0] a, input logic [3:0] w, input logic [DW-1:0] d);
    exp_q.push_back({a, w, d});
  endtask

  // Each byte i lives at byte address base+i; bytes sharing a word address
  // form one write.
  task automatic model_store(input logic [AW-1:0] base, input int cnt);
    logic [AW-1:0] a, cur_word;
    logic [3:0] wen;
    logic [DW-1:0] din;
    int lane;
    cur_word = base & ~32'd3;
    wen = '0;
    din = '0;
    for (int i = 0; i < cnt; i++) begin
      a = base + AW'(i);
      if ((a & ~32'd3) != cur_word) begin
        push_exp(cur_word, wen, din);
        cur_word = a & ~32'd3;
        wen = '0;
        din = '0;
      end
      lane = int'(a[1:0]);
      din[lane*8 +: 8] = ref_byte(bytes_q[i]);
      wen[lane] = 1'b1;
    end
    if (cnt > 0) push_exp(cur_word, wen, din);
  endtask

  // ---------------- BRAM port monitor ----------------
  always @(negedge clk) begin
    if (bus.BRAM_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_en", EW'(bus.BRAM_en), '0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("bram_write", {bus.BRAM_addr, bus.BRAM_wen, bus.BRAM_din}, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_outputs(input string tag);
    check(tag, EW'({bus.done, bus.act_ready, bus.BRAM_en, bus.BRAM_wen, bus.BRAM_addr, bus.BRAM_din}), '0);
  endtask

  task automatic drive_store(input logic [AW-1:0] base, input int cnt, input int max_gap,
                             input int gap_at, input int gap_len, input bit poke, input int abort_at);
    bit hs;
    int waited;
    int g;
    bus.store_start = 1'b1;
    bus.base_addr = base;
    bus.count = 16'(cnt);
    @(posedge clk); #1;
    bus.store_start = 1'b0;
    if (cnt == 0) begin
      check("done_after_zero", EW'(bus.done), 1);
      check("ready_after_zero", EW'(bus.act_ready), 0);
      repeat (2) @(posedge clk);
      #1;
      check("done_held", EW'(bus.done), 1);
      return;
    end
    check("done_cleared", EW'(bus.done), 0);
    for (int i = 0; i < cnt; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("reset_mid_store");
        return;
      end
      g = (i == gap_at) ? gap_len : ((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      bus.act_valid = 1'b0;
      repeat (g) begin
        @(posedge clk); #1;
      end
      bus.act_valid = 1'b1;
      bus.act_data = bytes_q[i];
      if (poke && i == 1) begin
        bus.store_start = 1'b1;
        bus.base_addr = $urandom;
        bus.count = 16'($urandom_range(1, 50));
      end
      waited = 0;
      do begin
        @(negedge clk);
        hs = bus.act_ready;
        @(posedge clk); #1;
        bus.store_start = 1'b0;
        waited++;
      end while (!hs && waited < 16);
      if (!hs) begin
        check("handshake_timeout", EW'(hs), 1);
        bus.act_valid = 1'b0;
        return;
      end
    end
    bus.act_valid = 1'b0;
    waited = 0;
    while (bus.done !== 1'b1 && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    check("done_latency", EW'(waited), 1);
    check("missing_writes", EW'(exp_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] base;
    int cnt;

    rst = 1'b1;
    bus.store_start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.act_data = '0;
    bus.act_valid = 1'b0;
    bus.BRAM_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst = 1'b0;

    // act_valid while idle must not be consumed
    bus.act_valid = 1'b1;
    bus.act_data = 8'h5A;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ready", EW'(bus.act_ready), 0);
    end
    bus.act_valid = 1'b0;

    // aligned
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_exp(32'h100, 4'hF, 32'h04030201);
    push_exp(32'h104, 4'hF, 32'h08070605);
    drive_store(32'h100, 8, 0, -1, 0, 1'b0, -1);

    // unaligned start and end
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    push_exp(32'h200, 4'hC, 32'hBBAA0000);
    push_exp(32'h204, 4'h7, 32'h00EEDDCC);
    drive_store(32'h202, 5, 0, -1, 0, 1'b0, -1);

    // backpressure: 3 idle cycles after byte 2
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_exp(32'h100, 4'hF, 32'h04030201);
    push_exp(32'h104, 4'hF, 32'h08070605);
    drive_store(32'h100, 8, 0, 2, 3, 1'b0, -1);

    // empty store
    drive_store(32'h300, 0, 0, -1, 0, 1'b0, -1);

    // store_start during a transfer is ignored
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_exp(32'h100, 4'hF, 32'h04030201);
    push_exp(32'h104, 4'hF, 32'h08070605);
    drive_store(32'h100, 8, 0, -1, 0, 1'b1, -1);

    // reset after 2 of 4 bytes, then a clean store
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_store(32'h400, 4, 0, -1, 0, 1'b0, 2);
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_exp(32'h0, 4'hF, 32'h44332211);
    drive_store(32'h0, 4, 0, -1, 0, 1'b0, -1);

    // sign-bit bytes
    bytes_q = '{8'h7F, 8'h80, 8'hFF, 8'h01};
`ifdef STORE_ACTIVATION_RELU_EN
    push_exp(32'h0, 4'hF, 32'h0100007F);
`else
    push_exp(32'h0, 4'hF, 32'h01FF807F);
`endif
    drive_store(32'h0, 4, 0, -1, 0, 1'b0, -1);

    // address wrap
    bytes_q.delete();
    for (int i = 0; i < 7; i++) bytes_q.push_back(8'($urandom));
    model_store(32'hFFFF_FFFD, 7);
    drive_store(32'hFFFF_FFFD, 7, 1, -1, 0, 1'b0, -1);

    // randomized stores against the model
    for (int t = 0; t < 30; t++) begin
      base = $urandom;
      cnt = int'($urandom_range(1, 20));
      bytes_q.delete();
      for (int i = 0; i < cnt; i++) bytes_q.push_back(8'($urandom));
      model_store(base, cnt);
      drive_store(base, cnt, 2, -1, 0, (cnt >= 2) && ($urandom_range(0, 3) == 0), -1);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", EW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_activation.md
Name: store_activation

Overview:
- Writer-side counterpart of the activation loader: takes the 8-bit output activations produced by the conv datapath and writes them back into activation BRAM.
- Packs the byte stream into 32-bit words, drives per-byte write enables and supports an unaligned start byte address.
- Sits between the PE-array result stream and the BRAM write port; the layer controller triggers it with store_start and polls done.

Parameters:
BRAM_ADDR_BIT, 32, BRAM byte-address width
BRAM_WIDTH, 32, BRAM data word width (4 bytes)
WEIGHT_WIDTH, 8, activation byte width
BRAM_BYTE, BRAM_WIDTH/8, number of byte-enable lanes

Ports:
clk  input  1  clock; the single clock for the block
rst  input  1  reset; synchronous, active-high
store_start  input  1  start pulse; sampled in IDLE only
base_addr  input  BRAM_ADDR_BIT  byte address of the first byte
count  input  16  number of bytes to store
act_data  input  WEIGHT_WIDTH  activation byte
act_valid  input  1  act_data valid
act_ready  output  1  block accepts a byte
done  output  1  store finished; held until the next accepted store_start
BRAM_clk  output  1  tied to clk
BRAM_en  output  1  registered write strobe
BRAM_rst  output  1  tied 0
BRAM_wen  output  BRAM_BYTE  registered byte write enables
BRAM_addr  output  BRAM_ADDR_BIT  registered word-aligned byte address (bits [1:0] = 0)
BRAM_din  output  BRAM_WIDTH  registered packed write data
BRAM_dout  input  BRAM_WIDTH  unused; present for port completeness

Behaviour:
- Reset values: done=0, act_ready=0, BRAM_en=0, BRAM_wen=0, BRAM_addr=0, BRAM_din=0. Internal state returns to IDLE; lane=0; buffer cleared.
- States: IDLE, COLLECT, FINISH.
- IDLE:
  - act_ready=0.
  - On store_start with count!=0: latch remaining=count, lane=base_addr[1:0], word_addr={base_addr[MSB:2],2'b00}; clear done; go to COLLECT.
  - On store_start with count==0: done=1 next cycle, no BRAM access, stay IDLE.
- COLLECT:
  - act_ready=1 combinationally.
  - Handshake = act_valid && act_ready. On each handshake: write the byte into buffer lane `lane` (bits [8*lane +: 8]), set the matching lane-enable bit, decrement remaining, increment lane (mod 4).
  - Flush when the handshake has lane==3 or remaining==1. Next cycle: BRAM_en=1, BRAM_wen=accumulated enables (including the current byte), BRAM_din=buffer (including the current byte), BRAM_addr=word_addr. In the same cycle: buffer and enables clear, word_addr+=4, lane=0.
  - Disabled lanes of BRAM_din drive 0.
  - BRAM_en/BRAM_wen drop to 0 on any cycle without a flush.
  - Back-to-back bytes are accepted every cycle with no stall; one write per cycle at most.
  - The flush on the last byte moves to FINISH.
- FINISH: one cycle; the final write strobe is on the BRAM port this cycle. Next cycle done=1 and state=IDLE.
- Latency: last byte accepted at cycle N -> write strobe at N+1 -> done high at N+2.
- store_start outside IDLE is ignored. act_valid outside COLLECT is ignored; no byte is consumed.
- word_addr wraps modulo 2^BRAM_ADDR_BIT; no error is raised.
- rst mid-operation: any partial word is discarded, no write is issued, done=0.

Optional Feature:
STORE_ACTIVATION_RELU_EN
- Defined: act_data is treated as signed; a byte with bit 7 set is written as 8'h00 (ReLU before storage). Enables and counting are unchanged.
- Undefined: bytes are stored unmodified.

Test Plan:
- Aligned store: base_addr=0x100, count=8, bytes 01..08 back-to-back -> writes (0x100, wen=4'hF, din=0x04030201) and (0x104, wen=4'hF, din=0x08070605); done=1 two cycles after the last byte.
- Unaligned start/end: base_addr=0x202, count=5, bytes AA..EE -> (0x200, wen=4'hC, din=0xBBAA0000), (0x204, wen=4'h7, din=0x00EEDDCC).
- Backpressure: same as the aligned case but act_valid deasserted for 3 cycles after byte 2 -> identical writes; no BRAM_en during the gap.
- count=0 -> no BRAM_en; done=1 in the cycle after store_start. A store_start issued mid-transfer is ignored (write sequence unchanged).
- rst asserted after 2 of 4 bytes -> no write; all outputs back to reset values. A subsequent store with base_addr=0x0, count=4, bytes 11..44 writes 0x44332211.
- With STORE_ACTIVATION_RELU_EN: bytes 7F,80,FF,01 at 0x0 -> din=0x0100007F. Without it -> din=0x01FF807F.
